// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM bridge: response codes, word geometry
// and the bridge FSM state encoding.
package axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int         WORD_BYTES    = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR_COLLECT,
        WR_EN,
        WR_RESP,
        RD_EN,
        RD_DATA,
        RD_RESP
    } bridge_state_e;

endpackage

// File: rtl/axi_sram_bridge.sv
// Single-outstanding AXI4 slave (len=0 only) that maps each beat onto a
// synchronous single-port SRAM with 1-cycle read latency; writes win over reads.
module axi_sram_bridge
    import axi_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [31:0]       awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam int OFF = $clog2(WORD_BYTES);

    bridge_state_e     state_q, state_d;
    logic              rst_done_q;
    logic              have_aw_q, have_w_q;
    logic [ADDR_W-1:0] aw_word_q, ar_word_q;
    logic [31:0]       wdata_q, rdata_q;
    logic [3:0]        wstrb_q;

    // Byte-offset and above-range address bits are deliberately dropped (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{araddr[31:ADDR_W+OFF], araddr[OFF-1:0],
                                awaddr[31:ADDR_W+OFF], awaddr[OFF-1:0]};

    // NOTE: every signal assigned in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        awready = 1'b0;
        wready  = 1'b0;
        arready = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_done_q) begin
                    awready = 1'b1;
                    wready  = 1'b1;
                    arready = !awvalid && !wvalid;
                    if (awvalid && wvalid)      state_d = WR_EN;
                    else if (awvalid || wvalid) state_d = WR_COLLECT;
                    else if (arvalid)           state_d = RD_EN;
                end
            end
            WR_COLLECT: begin
                awready = !have_aw_q;
                wready  = !have_w_q;
                if ((awready && awvalid) || (wready && wvalid)) state_d = WR_EN;
            end
            WR_EN:   state_d = WR_RESP;
            WR_RESP: if (bready) state_d = IDLE;
            RD_EN:   state_d = RD_DATA;
            RD_DATA: state_d = RD_RESP;
            RD_RESP: if (rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            rst_done_q <= 1'b0;
            have_aw_q  <= 1'b0;
            have_w_q   <= 1'b0;
            aw_word_q  <= '0;
            ar_word_q  <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
            if (state_q == WR_EN) begin
                have_aw_q <= 1'b0;
                have_w_q  <= 1'b0;
            end
            if (awready && awvalid) begin
                aw_word_q <= awaddr[ADDR_W+OFF-1:OFF];
                have_aw_q <= 1'b1;
            end
            if (wready && wvalid) begin
                wdata_q  <= wdata;
                wstrb_q  <= wstrb;
                have_w_q <= 1'b1;
            end
            if (arready && arvalid) ar_word_q <= araddr[ADDR_W+OFF-1:OFF];
            if (state_q == RD_DATA) rdata_q <= sram_rdata;
        end
    end

    // An all-zero strobe must not turn into an SRAM read, hence the |wstrb_q gate.
    assign sram_en    = (state_q == RD_EN) || ((state_q == WR_EN) && (|wstrb_q));
    assign sram_we    = (state_q == WR_EN) ? wstrb_q : 4'b0000;
    assign sram_addr  = (state_q == WR_EN) ? aw_word_q : ar_word_q;
    assign sram_wdata = wdata_q;

    assign rvalid = (state_q == RD_RESP);
    assign rdata  = rdata_q;
    assign rresp  = AXI_RESP_OKAY;
    assign rlast  = 1'b1;
    assign bvalid = (state_q == WR_RESP);
    assign bresp  = AXI_RESP_OKAY;

endmodule
